// File: rtl/demux_1x8_scan_ctrl.sv
// demux_1x8_scan_ctrl
// Scan sequencer for a 1x8 demultiplexer. It walks the enabled channels in
// ascending order and holds each one for a programmable dwell. Channel changes
// are break-before-make: one GAP cycle with the demux input forced low.
// Operates as a single pass or as a continuous scan, with a start/stop/busy/done
// handshake and a count of completed passes.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | not scanning; sel_out=0; waiting for start
// ACTIVE | routing data_in to channel sel_out; dwell down-counter running
// GAP    | demux input held low for one cycle; sel_out already at next channel
module demux_1x8_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               data_in,
  output logic [2:0]         sel_out,
  output logic               demux_in,
  output logic               busy,
  output logic               done,
  output logic [7:0]         pass_cnt
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         sel_q, sel_d;
  logic [7:0]         mask_q, mask_d;
  logic               mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;   // captured dwell, already clamped to >= 1
  logic [DWELL_W-1:0] cnt_q, cnt_d;       // ACTIVE cycles left after the current one
  logic               done_q, done_d;
  logic [7:0]         pass_q, pass_d;

  logic [DWELL_W-1:0] dwell_eff;
  logic [7:0]         mask_above;
  logic               has_next;
  logic [2:0]         next_ch;
  logic [2:0]         first_ch;
  logic [2:0]         start_ch;

  // Lowest set bit of a channel mask; returns 0 for an empty mask.
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) r = 3'(k);
    end
    return r;
  endfunction

  // Channel search helpers: a zero dwell is run as a one-cycle dwell.
  always_comb begin
    dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
    mask_above = mask_q & (8'hFE << sel_q);
    has_next   = |mask_above;
    next_ch    = lowest_ch(mask_above);
    first_ch   = lowest_ch(mask_q);
    start_ch   = lowest_ch(ch_mask);
  end

  // Next-state logic for the scan FSM and its datapath registers.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ch_mask != 8'h00) begin
            state_d = S_ACTIVE;
            sel_d   = start_ch;
            mask_d  = ch_mask;
            mode_d  = mode;
            dwell_d = dwell_eff;
            cnt_d   = dwell_eff - 1'b1;
            pass_d  = 8'h00;
          end else begin
            // Nothing to scan: report completion at once. The pass count is
            // left alone because no scan was actually started.
            done_d = 1'b1;
          end
        end
      end

      S_ACTIVE: begin
        if (stop) begin
          state_d = S_IDLE;
          sel_d   = 3'd0;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          if (has_next) begin
            state_d = S_GAP;
            sel_d   = next_ch;
          end else begin
            pass_d = pass_q + 8'd1;
            if (mode_q) begin
              state_d = S_GAP;
              sel_d   = first_ch;
            end else begin
              state_d = S_IDLE;
              sel_d   = 3'd0;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
          sel_d   = 3'd0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ACTIVE;
          cnt_d   = dwell_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        sel_d   = 3'd0;
      end
    endcase
  end

  // State and datapath registers; reset clears everything, even mid-scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      mask_q  <= 8'h00;
      mode_q  <= 1'b0;
      dwell_q <= '0;
      cnt_q   <= '0;
      pass_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Outputs: demux input is gated only by the registered state.
  always_comb begin
    sel_out  = sel_q;
    busy     = (state_q != S_IDLE);
    demux_in = (state_q == S_ACTIVE) & data_in;
    done     = done_q;
    pass_cnt = pass_q;
  end

endmodule

// File: tb/tb_demux_1x8_scan_ctrl.sv
// Self-checking bench for demux_1x8_scan_ctrl. The reference model expands each
// accepted scan into a queue of per-cycle (channel, active) slots and pops one
// slot per clock.
module tb_demux_1x8_scan_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] ch_mask;
  logic [7:0] dwell;
  logic       data_in;
  logic [2:0] sel_out;
  logic       demux_in;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;

  demux_1x8_scan_ctrl #(.DWELL_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .mode     (mode),
    .ch_mask  (ch_mask),
    .dwell    (dwell),
    .data_in  (data_in),
    .sel_out  (sel_out),
    .demux_in (demux_in),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  function automatic void chk(string nm, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0] sel;
    logic       act;
  } slot_t;

  slot_t      sched[$];
  bit         m_busy = 0;
  bit         m_act  = 0;
  bit         m_done = 0;
  logic [2:0] m_sel  = 3'd0;
  logic [7:0] m_pass = 8'd0;
  logic [7:0] c_mask = 8'd0;
  bit         c_mode = 0;
  int         c_d    = 1;

  // One full pass: every enabled channel for d cycles, a gap slot before each
  // channel except (optionally) the first.
  function automatic void build_pass(bit lead_gap);
    bit first = 1;
    for (int k = 0; k < 8; k++) begin
      if (c_mask[k]) begin
        if (!first || lead_gap) sched.push_back('{sel: 3'(k), act: 1'b0});
        for (int j = 0; j < c_d; j++) sched.push_back('{sel: 3'(k), act: 1'b1});
        first = 0;
      end
    end
  endfunction

  function automatic void pop_slot();
    slot_t s;
    s     = sched.pop_front();
    m_sel = s.sel;
    m_act = s.act;
  endfunction

  function automatic void go_idle();
    m_busy = 0;
    m_act  = 0;
    m_sel  = 3'd0;
    sched.delete();
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      go_idle();
      m_done = 0;
      m_pass = 8'd0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          if (ch_mask != 8'h00) begin
            c_mask = ch_mask;
            c_mode = mode;
            c_d    = (dwell == 0) ? 1 : int'(dwell);
            m_pass = 8'd0;
            sched.delete();
            build_pass(0);
            pop_slot();
            m_busy = 1;
          end else begin
            m_done = 1;
          end
        end
      end else if (stop) begin
        go_idle();
        m_done = 1;
      end else if (sched.size() == 0) begin
        m_pass = m_pass + 8'd1;
        if (c_mode) begin
          build_pass(1);
          pop_slot();
        end else begin
          go_idle();
          m_done = 1;
        end
      end else begin
        pop_slot();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("sel_out",  sel_out,  m_sel);
      chk("demux_in", demux_in, m_act & data_in);
      chk("busy",     busy,     m_busy);
      chk("done",     done,     m_done);
      chk("pass_cnt", pass_cnt, m_pass);
    end
  end

  // ---------------- stimulus ----------------
  bit   data_ones = 0;
  int   obs_busy, obs_hi, obs_done;
  logic [7:0] obs_seen;

  task automatic clr_obs();
    obs_busy = 0; obs_hi = 0; obs_done = 0; obs_seen = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
    data_in = data_ones ? 1'b1 : 1'($urandom);
    #1;
    if (busy)     obs_busy++;
    if (done)     obs_done++;
    if (demux_in) begin
      obs_hi++;
      obs_seen[sel_out] = 1'b1;
    end
  endtask

  task automatic launch(input logic [7:0] m, input logic [7:0] d, input logic md);
    ch_mask = m; dwell = d; mode = md;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int got;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    ch_mask = 8'h00; dwell = 8'd0; data_in = 1'b0;
    clr_obs();
    repeat (3) tick();
    chk("rst_sel",  sel_out,  0);
    chk("rst_busy", busy,     0);
    chk("rst_done", done,     0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Full single pass, dwell 2.
    data_ones = 1;
    clr_obs();
    launch(8'hFF, 8'd2, 1'b0);
    repeat (30) tick();
    chk("A_busy_cycles", obs_busy, 23);
    chk("A_active_hi",   obs_hi,   16);
    chk("A_done_pulses", obs_done, 1);
    chk("A_seen",        obs_seen, 8'hFF);
    chk("A_pass_cnt",    pass_cnt, 1);

    // Continuous 0x81, dwell 0, three passes then stop.
    clr_obs();
    launch(8'h81, 8'd0, 1'b1);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      if (pass_cnt == 8'd3) begin got = 1; break; end
      tick();
    end
    chk("B_reach_3_passes", got, 1);
    chk("B_active_hi", obs_hi, 6);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("B_done",     done,     1);
    chk("B_busy",     busy,     0);
    chk("B_pass_cnt", pass_cnt, 3);
    chk("B_seen",     obs_seen, 8'h81);
    tick();

    // Empty mask start.
    clr_obs();
    launch(8'h00, 8'd3, 1'b0);
    chk("C_done",  done,    1);
    chk("C_busy",  busy,    0);
    chk("C_sel",   sel_out, 0);
    tick();
    chk("C_done_clear", done, 0);
    repeat (3) tick();
    chk("C_busy_never", obs_busy, 0);
    chk("C_done_once",  obs_done, 1);

    // Stop coincident with dwell expiry on the first channel.
    launch(8'h0F, 8'd3, 1'b0);
    tick();
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("D_busy", busy,    0);
    chk("D_done", done,    1);
    chk("D_sel",  sel_out, 0);
    tick();

    // Start while busy is ignored.
    launch(8'hFF, 8'd1, 1'b1);
    got = 0;
    for (int i = 0; i < 60; i++) begin
      if (pass_cnt == 8'd1) begin got = 1; break; end
      tick();
    end
    chk("E_reach_pass", got, 1);
    ch_mask = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("E_busy",     busy,     1);
    chk("E_pass_cnt", pass_cnt, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();

    // Settings are captured at start.
    clr_obs();
    launch(8'h24, 8'd3, 1'b0);
    ch_mask = 8'hFF; dwell = 8'd1; mode = 1'b1;
    repeat (15) tick();
    chk("F_busy_cycles", obs_busy, 7);
    chk("F_active_hi",   obs_hi,   6);
    chk("F_seen",        obs_seen, 8'h24);
    chk("F_done_pulses", obs_done, 1);
    chk("F_pass_cnt",    pass_cnt, 1);

    // Randomized scans with random stop/start traffic and random data.
    data_ones = 0;
    for (int it = 0; it < 40; it++) begin
      int len;
      launch(($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
             8'($urandom_range(0, 4)), 1'($urandom));
      len = $urandom_range(10, 60);
      for (int c = 0; c < len; c++) begin
        stop    = ($urandom_range(0, 29) == 0);
        start   = ($urandom_range(0, 19) == 0);
        ch_mask = 8'($urandom);
        dwell   = 8'($urandom_range(0, 4));
        mode    = 1'($urandom);
        tick();
      end
      start = 1'b0;
      stop  = 1'b0;
      if (busy) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
      tick();
    end

    // Asynchronous reset in the middle of an ACTIVE dwell.
    data_ones = 1;
    launch(8'hFF, 8'd5, 1'b1);
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (pass_cnt == 8'd1 && sel_out == 3'd3 && demux_in) begin got = 1; break; end
      tick();
    end
    chk("R_reach_ch3", got, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("R_sel",   sel_out,  0);
    chk("R_demux", demux_in, 0);
    chk("R_busy",  busy,     0);
    chk("R_done",  done,     0);
    chk("R_pass",  pass_cnt, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
